// File: rtl/display_scanner_if.sv
// Scan interface: BCD time and mode in from the timekeeping core,
// one registered (location, digit) pair plus colon/tick out to the segment driver.
interface display_scanner_if;
  logic [23:0] time_bcd;
  logic [1:0]  mode;
  logic [1:0]  location;
  logic [3:0]  digit;
  logic        col_on;
  logic        scan_tick;

  modport master (
    output time_bcd, mode,
    input  location, digit, col_on, scan_tick
  );

  modport slave (
    input  time_bcd, mode,
    output location, digit, col_on, scan_tick
  );
endinterface

// File: rtl/display_scanner.sv
// Time-multiplexes four BCD display positions, one registered update every REFRESH_DIV cycles.
// No backpressure: the downstream driver samples location/digit on scan_tick; inputs reach outputs only through registers.
module display_scanner #(
  parameter int REFRESH_DIV  = 12500,
  parameter int BLINK_FRAMES = 125
) (
  input logic              M_CLOCK,
  input logic              M_RESETN,
  display_scanner_if.slave scan_if
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [3:0]    BLANK      = 4'hF;

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'b00,
    MODE_SEC    = 2'b01,
    MODE_MIN    = 2'b10,
    MODE_HOUR   = 2'b11
  } mode_e;

  // Position 3 is leftmost; seconds-set slides the window right by one field.
  function automatic logic [3:0] pick_digit(
    input logic [23:0] t,
    input mode_e       md,
    input logic [1:0]  pos,
    input logic        vis
  );
    logic [3:0] nib;
    logic       hide;
    if (md == MODE_SEC) begin
      case (pos)
        2'd3:    nib = t[15:12];
        2'd2:    nib = t[11:8];
        2'd1:    nib = t[7:4];
        default: nib = t[3:0];
      endcase
    end else begin
      case (pos)
        2'd3:    nib = t[23:20];
        2'd2:    nib = t[19:16];
        2'd1:    nib = t[15:12];
        default: nib = t[11:8];
      endcase
    end
    hide = (nib > 4'd9);
    if (md == MODE_NORMAL && pos == 2'd3 && nib == 4'd0) hide = 1'b1;
    if (!vis) begin
      if (md == MODE_HOUR && pos[1]) hide = 1'b1;
      if ((md == MODE_MIN || md == MODE_SEC) && !pos[1]) hide = 1'b1;
    end
    return hide ? BLANK : nib;
  endfunction

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    loc_q, loc_d;
  logic [3:0]    digit_q, digit_d;
  logic          col_q, col_d;
  logic          tick_q, tick_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          phase_q, phase_d;
  logic [23:0]   shadow_q, shadow_d;
  mode_e         last_mode_q, last_mode_d;

  mode_e mode_in;
  logic  tc;
  logic  wrap;
  logic  mode_chg;

  assign mode_in  = mode_e'(scan_if.mode);
  assign tc       = (presc_q == PRESC_LAST);
  assign wrap     = tc && (loc_q == 2'd0);
  assign mode_chg = (mode_in != last_mode_q);

  always_comb begin
    presc_d     = tc ? '0 : presc_q + 1'b1;
    loc_d       = tc ? loc_q - 2'd1 : loc_q;
    shadow_d    = wrap ? scan_if.time_bcd : shadow_q;
    last_mode_d = mode_in;
    tick_d      = tc;
    frame_d     = frame_q;
    phase_d     = phase_q;
    if (wrap) begin
      if (frame_q == FRAME_LAST) begin
        frame_d = '0;
        phase_d = ~phase_q;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end
    // A mode change re-arms the blink so the field being edited shows at once.
    if (mode_chg) begin
      frame_d = '0;
      phase_d = 1'b1;
    end
    digit_d = digit_q;
    col_d   = col_q;
    if (tc) begin
      digit_d = pick_digit(shadow_d, mode_in, loc_d, phase_d);
      col_d   = (mode_in == MODE_NORMAL) ? phase_d : 1'b1;
    end
  end

  always_ff @(posedge M_CLOCK or negedge M_RESETN) begin
    if (!M_RESETN) begin
      presc_q     <= '0;
      loc_q       <= 2'd3;
      digit_q     <= BLANK;
      col_q       <= 1'b1;
      tick_q      <= 1'b0;
      frame_q     <= '0;
      phase_q     <= 1'b1;
      shadow_q    <= '0;
      last_mode_q <= MODE_NORMAL;
    end else begin
      presc_q     <= presc_d;
      loc_q       <= loc_d;
      digit_q     <= digit_d;
      col_q       <= col_d;
      tick_q      <= tick_d;
      frame_q     <= frame_d;
      phase_q     <= phase_d;
      shadow_q    <= shadow_d;
      last_mode_q <= last_mode_d;
    end
  end

  assign scan_if.location  = loc_q;
  assign scan_if.digit     = digit_q;
  assign scan_if.col_on    = col_q;
  assign scan_if.scan_tick = tick_q;

endmodule

// File: tb/tb_display_scanner.sv
// Bench for display_scanner: fixed vector table, hand sequences for tearing/mode/reset,
// and a randomized run against a frame-level reference model.
module tb_display_scanner;
  localparam int DIV = 4;
  localparam int BF  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  display_scanner_if sif();

  display_scanner #(.REFRESH_DIV(DIV), .BLINK_FRAMES(BF)) dut (
    .M_CLOCK (clk),
    .M_RESETN(rst_n),
    .scan_if (sif)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: cycles since release, displayed pair, frame snapshot,
  // and number of frame wraps since the last mode change.
  int          m_cnt;
  int          m_loc;
  logic [3:0]  m_dig;
  logic        m_col;
  logic        m_tick;
  logic [23:0] m_snap;
  int          m_frames;
  logic [1:0]  m_last;

  typedef struct {
    logic [23:0] t;
    logic [1:0]  md;
    logic [15:0] vis;
    logic [15:0] hid;
    logic        cv;
    logic        ch;
  } row_t;

  row_t rows [8];

  function automatic logic [3:0] ref_digit(input logic [23:0] t, input logic [1:0] md,
                                           input int pos, input bit vis);
    logic [3:0] nib [6];
    logic [3:0] val;
    for (int i = 0; i < 6; i++) nib[i] = t[4*i +: 4];
    val = (md == 2'd1) ? nib[pos] : nib[pos+2];
    if (val > 4'd9) return 4'hF;
    if (md == 2'd0 && pos == 3 && val == 4'd0) return 4'hF;
    if (!vis && ((md == 2'd3 && pos >= 2) || ((md == 2'd1 || md == 2'd2) && pos <= 1)))
      return 4'hF;
    return val;
  endfunction

  function automatic void model_step();
    bit tc;
    bit chg;
    bit vis;
    tc     = (m_cnt % DIV) == DIV - 1;
    m_cnt  = m_cnt + 1;
    chg    = (sif.mode != m_last);
    m_last = sif.mode;
    if (tc) begin
      m_loc = (m_loc + 3) % 4;
      if (m_loc == 3) begin
        m_snap   = sif.time_bcd;
        m_frames = m_frames + 1;
      end
    end
    if (chg) m_frames = 0;
    vis = ((m_frames / BF) % 2) == 0;
    if (tc) begin
      m_dig  = ref_digit(m_snap, sif.mode, m_loc, vis);
      m_col  = (sif.mode == 2'd0) ? vis : 1'b1;
      m_tick = 1'b1;
    end else begin
      m_tick = 1'b0;
    end
  endfunction

  function automatic logic [31:0] dut_out();
    return {24'd0, sif.location, sif.digit, sif.col_on, sif.scan_tick};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check("cycle", dut_out(), {24'd0, 2'(m_loc), m_dig, m_col, m_tick});
  endtask

  task automatic adv_tick();
    repeat (DIV) cyc();
  endtask

  task automatic expect_tick(input string name, input int loc, input logic [3:0] d, input logic c);
    adv_tick();
    check(name, dut_out(), {24'd0, 2'(loc), d, c, 1'b1});
  endtask

  task automatic hard_reset(input logic [23:0] t, input logic [1:0] md);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", dut_out(), {24'd0, 2'd3, 4'hF, 1'b1, 1'b0});
    m_cnt    = 0;
    m_loc    = 3;
    m_dig    = 4'hF;
    m_col    = 1'b1;
    m_tick   = 1'b0;
    m_snap   = '0;
    m_frames = 0;
    m_last   = 2'd0;
    sif.time_bcd = t;
    sif.mode     = md;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [23:0] rand_time();
    logic [23:0] t;
    for (int i = 0; i < 6; i++) t[4*i +: 4] = 4'($urandom_range(0, 11));
    return t;
  endfunction

  initial begin
    logic [15:0] v;
    logic [15:0] h;
    sif.time_bcd = '0;
    sif.mode     = 2'd0;

    rows[0] = '{24'h123456, 2'd0, 16'h1234, 16'h1234, 1'b1, 1'b0};
    rows[1] = '{24'h093000, 2'd0, 16'hF930, 16'hF930, 1'b1, 1'b0};
    rows[2] = '{24'h093000, 2'd3, 16'h0930, 16'hFF30, 1'b1, 1'b1};
    rows[3] = '{24'h125947, 2'd1, 16'h5947, 16'h59FF, 1'b1, 1'b1};
    rows[4] = '{24'h123C56, 2'd0, 16'h123F, 16'h123F, 1'b1, 1'b0};
    rows[5] = '{24'h2359A0, 2'd1, 16'h59F0, 16'h59FF, 1'b1, 1'b1};
    rows[6] = '{24'h000000, 2'd2, 16'h0000, 16'h00FF, 1'b1, 1'b1};
    rows[7] = '{24'h000000, 2'd0, 16'hF000, 16'hF000, 1'b1, 1'b0};

    // Power-up scan: reset shadow first, then 1,2,3,4 with colon flipping every two frames.
    hard_reset(24'h123456, 2'd0);
    for (int k = 1; k <= 17; k++) begin
      int         loc;
      logic [3:0] d;
      logic       c;
      loc = 3 - (k % 4);
      d   = (k <= 3) ? 4'd0 : 4'(4 - loc);
      c   = ((k / 4) / 2) % 2 == 0;
      expect_tick($sformatf("scan_k%0d", k), loc, d, c);
    end
    cyc();

    for (int r = 0; r < 8; r++) begin
      v = rows[r].vis;
      h = rows[r].hid;
      hard_reset(rows[r].t, rows[r].md);
      repeat (3) adv_tick();
      for (int p = 3; p >= 0; p--)
        expect_tick($sformatf("row%0d_vis_p%0d", r, p), p, v[4*p +: 4], rows[r].cv);
      for (int p = 3; p >= 0; p--)
        expect_tick($sformatf("row%0d_hid_p%0d", r, p), p, h[4*p +: 4], rows[r].ch);
    end

    // Time changes while position 1 is shown; the rest of the frame keeps the old snapshot.
    hard_reset(24'h123456, 2'd0);
    repeat (6) adv_tick();
    sif.time_bcd = 24'h125900;
    expect_tick("tear_old_mo", 0, 4'd4, 1'b1);
    expect_tick("tear_new_p3", 3, 4'd1, 1'b0);
    expect_tick("tear_new_p2", 2, 4'd2, 1'b0);
    expect_tick("tear_new_p1", 1, 4'd5, 1'b0);
    expect_tick("tear_new_p0", 0, 4'd9, 1'b0);
    cyc();

    // Enter MINUTE-set during a hidden frame: minutes show at once and the blink restarts.
    hard_reset(24'h123456, 2'd0);
    repeat (12) adv_tick();
    expect_tick("mc_pre", 2, 4'd2, 1'b0);
    sif.mode = 2'd2;
    expect_tick("mc_p1", 1, 4'd3, 1'b1);
    expect_tick("mc_p0", 0, 4'd4, 1'b1);
    expect_tick("mc_f1_p3", 3, 4'd1, 1'b1);
    expect_tick("mc_f1_p2", 2, 4'd2, 1'b1);
    expect_tick("mc_f1_p1", 1, 4'd3, 1'b1);
    expect_tick("mc_f1_p0", 0, 4'd4, 1'b1);
    expect_tick("mc_f2_p3", 3, 4'd1, 1'b1);
    expect_tick("mc_f2_p2", 2, 4'd2, 1'b1);
    expect_tick("mc_f2_p1", 1, 4'hF, 1'b1);
    expect_tick("mc_f2_p0", 0, 4'hF, 1'b1);
    cyc();

    hard_reset(rand_time(), 2'($urandom_range(0, 3)));
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) sif.time_bcd = rand_time();
      if ($urandom_range(0, 63) == 0) sif.mode = 2'($urandom_range(0, 3));
      if (i == 777) hard_reset(rand_time(), 2'($urandom_range(0, 3)));
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
